// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and an aux port.
// Fixed CORE priority with an AUX starvation guard; define DMEM_ARB_ROUND_ROBIN_EN for alternating fairness.
module data_memory_arbiter #(
  parameter int data_bits = 32,
  parameter int MAX_WAIT  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_req,
  input  logic                          core_we,
  input  logic [data_bits-1:0]          core_addr,
  input  logic [data_bits-1:0]          core_wdata,
  output logic                          core_gnt,
  output logic                          core_stall,
  output logic [data_bits-1:0]          core_rdata,
  output logic                          core_rvalid,
  input  logic                          aux_req,
  input  logic                          aux_we,
  input  logic [data_bits-1:0]          aux_addr,
  input  logic [data_bits-1:0]          aux_wdata,
  output logic                          aux_gnt,
  output logic [data_bits-1:0]          aux_rdata,
  output logic                          aux_rvalid,
  output logic [data_bits-3:0]          mem_read_address,
  output logic [data_bits-1:0]          mem_input_data,
  output logic                          mem_write_enable,
  output logic                          mem_read_enable,
  input  logic [data_bits-1:0]          mem_read_data,
  output logic [1:0]                    dbg_rd_owner,
  output logic [$clog2(MAX_WAIT+1)-1:0] dbg_wait_cnt
);

  // Handshake: a requester holds req/we/addr/wdata until gnt; gnt means the access
  // reaches the memory this cycle, read data returns with rvalid on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   core_win, aux_win;
  logic   unused_addr_bits;

  assign unused_addr_bits = ^{core_addr[1:0], aux_addr[1:0]};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_aux_q, last_aux_d;

  always_comb begin
    core_win   = core_req & (~aux_req | last_aux_q);
    aux_win    = aux_req & ~core_win;
    last_aux_d = last_aux_q;
    if (core_gnt) last_aux_d = 1'b0;
    if (aux_gnt)  last_aux_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_aux_q <= 1'b0;
    else        last_aux_q <= last_aux_d;
  end

  assign dbg_wait_cnt = '0;
`else
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           starved;

  always_comb begin
    starved    = aux_req & (wait_cnt_q == MAX_W);
    core_win   = core_req & ~starved;
    aux_win    = aux_req & ~core_win;
    wait_cnt_d = '0;
    // Count only cycles AUX is actively denied; saturate so the forced grant holds.
    if (aux_req & ~aux_win)
      wait_cnt_d = (wait_cnt_q == MAX_W) ? MAX_W : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  assign dbg_wait_cnt = wait_cnt_q;
`endif

  always_comb begin
    core_gnt         = core_win & rst_n;
    aux_gnt          = aux_win & rst_n;
    core_stall       = core_req & ~core_gnt & rst_n;
    mem_read_address = aux_win ? aux_addr[data_bits-1:2] : core_addr[data_bits-1:2];
    mem_input_data   = aux_win ? aux_wdata : core_wdata;
    mem_write_enable = (core_gnt & core_we) | (aux_gnt & aux_we);
    mem_read_enable  = (core_gnt & ~core_we) | (aux_gnt & ~aux_we);
    rd_owner_d       = OWN_NONE;
    if (core_gnt & ~core_we)     rd_owner_d = OWN_CORE;
    else if (aux_gnt & ~aux_we)  rd_owner_d = OWN_AUX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_owner_q <= OWN_NONE;
    else        rd_owner_q <= rd_owner_d;
  end

  always_comb begin
    core_rvalid  = (rd_owner_q == OWN_CORE) & rst_n;
    aux_rvalid   = (rd_owner_q == OWN_AUX) & rst_n;
    core_rdata   = core_rvalid ? mem_read_data : '0;
    aux_rdata    = aux_rvalid ? mem_read_data : '0;
    dbg_rd_owner = rd_owner_q;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 1-cycle-latency memory.
// Covers reset, routing, starvation guard (or alternation when DMEM_ARB_ROUND_ROBIN_EN is set).
module tb_data_memory_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we, aux_req, aux_we;
  logic [31:0] core_addr, core_wdata, aux_addr, aux_wdata;
  logic        core_gnt, core_stall, core_rvalid, aux_gnt, aux_rvalid;
  logic [31:0] core_rdata, aux_rdata, mem_input_data, mem_read_data;
  logic [29:0] mem_read_address;
  logic        mem_write_enable, mem_read_enable;
  logic [1:0]  dbg_rd_owner;
  logic [3:0]  dbg_wait_cnt;

  int n_cmp = 0;
  int n_err = 0;

  data_memory_arbiter #(.data_bits(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rdata(core_rdata),
    .core_rvalid(core_rvalid),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_read_address(mem_read_address), .mem_input_data(mem_input_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data),
    .dbg_rd_owner(dbg_rd_owner), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words read back as C0DE_00xx with xx = word index.
  logic [31:0] mem [0:63];
  bit          written [0:63];
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_read_address[5:0]]     <= mem_input_data;
      written[mem_read_address[5:0]] <= 1'b1;
    end
    if (mem_read_enable)
      mem_read_data <= written[mem_read_address[5:0]] ? mem[mem_read_address[5:0]]
                                                      : {16'hC0DE, 10'b0, mem_read_address[5:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = 32'h0;
    aux_req  = 1'b1; aux_we  = 1'b0; aux_addr  = 32'h20; aux_wdata  = 32'h0;
    mem_read_data = 32'h0;

    // 1. reset with both requesting -> everything quiet
    tick(); tick();
    check("rst_core_gnt",   {31'b0, core_gnt}, 32'h0);
    check("rst_aux_gnt",    {31'b0, aux_gnt}, 32'h0);
    check("rst_core_stall", {31'b0, core_stall}, 32'h0);
    check("rst_rd_en",      {31'b0, mem_read_enable}, 32'h0);
    check("rst_wr_en",      {31'b0, mem_write_enable}, 32'h0);
    check("rst_rvalids",    {30'b0, core_rvalid, aux_rvalid}, 32'h0);
    check("rst_rdatas",     core_rdata | aux_rdata, 32'h0);
    rst_n = 1'b1; aux_req = 1'b0;
    #1;
    check("t1_addr",     {2'b0, mem_read_address}, 32'h4);
    check("t1_rd_en",    {31'b0, mem_read_enable}, 32'h1);
    check("t1_core_gnt", {31'b0, core_gnt}, 32'h1);
    tick();
    core_req = 1'b0;
    check("t1_core_rvalid", {31'b0, core_rvalid}, 32'h1);
    check("t1_core_rdata",  core_rdata, 32'hC0DE_0004);
    check("t1_aux_rvalid",  {31'b0, aux_rvalid}, 32'h0);

    // 2. aux write then core read of the same word
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h20; aux_wdata = 32'hDEAD_BEEF;
    #1;
    check("t2_aux_gnt", {31'b0, aux_gnt}, 32'h1);
    check("t2_wr_en",   {31'b0, mem_write_enable}, 32'h1);
    check("t2_addr",    {2'b0, mem_read_address}, 32'h8);
    check("t2_wdata",   mem_input_data, 32'hDEAD_BEEF);
    tick();
    aux_req = 1'b0; aux_we = 1'b0;
    check("t2_aux_no_rvalid", {31'b0, aux_rvalid}, 32'h0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
    #1;
    check("t2_core_gnt", {31'b0, core_gnt}, 32'h1);
    tick();
    core_req = 1'b0;
    check("t2_core_rvalid", {31'b0, core_rvalid}, 32'h1);
    check("t2_core_rdata",  core_rdata, 32'hDEAD_BEEF);

    // 3. both requesters held: starvation guard, or strict alternation
    core_req = 1'b1; core_addr = 32'h10; aux_req = 1'b1; aux_addr = 32'h20;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Last grant was CORE (test 2), so AUX goes first.
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_rr_aux_gnt",  {31'b0, aux_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check("t3_rr_core_gnt", {31'b0, core_gnt}, (i % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      check("t3_rr_aux_rvalid",  {31'b0, aux_rvalid}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check("t3_rr_core_rvalid", {31'b0, core_rvalid}, (i % 2 == 0) ? 32'h0 : 32'h1);
      check("t3_rr_rdata", aux_rdata | core_rdata, (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hC0DE_0004);
    end
`else
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_core_gnt", {31'b0, core_gnt}, 32'h1);
      check("t3_aux_gnt",  {31'b0, aux_gnt}, 32'h0);
      check("t3_wait_cnt", {28'b0, dbg_wait_cnt}, i);
      if (i > 0) check("t3_core_rvalid", {31'b0, core_rvalid}, 32'h1);
      tick();
    end
    #1;
    check("t3_forced_aux_gnt", {31'b0, aux_gnt}, 32'h1);
    check("t3_forced_core_gnt", {31'b0, core_gnt}, 32'h0);
    check("t3_core_stall",     {31'b0, core_stall}, 32'h1);
    check("t3_forced_addr",    {2'b0, mem_read_address}, 32'h8);
    check("t3_wait_sat",       {28'b0, dbg_wait_cnt}, 32'h8);
    tick();
    check("t3_aux_rvalid",  {31'b0, aux_rvalid}, 32'h1);
    check("t3_aux_rdata",   aux_rdata, 32'hDEAD_BEEF);
    check("t3_wait_clear",  {28'b0, dbg_wait_cnt}, 32'h0);
    check("t3_core_again",  {31'b0, core_gnt}, 32'h1);
    check("t3_stall_clear", {31'b0, core_stall}, 32'h0);
`endif
    core_req = 1'b0; aux_req = 1'b0;
    tick();

    // 5. reset during aux read return drops the return
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
    #1;
    check("t5_aux_gnt", {31'b0, aux_gnt}, 32'h1);
    tick();
    rst_n = 1'b0; aux_req = 1'b0;
    #1;
    check("t5_rvalid_in_rst", {31'b0, aux_rvalid}, 32'h0);
    check("t5_rdata_in_rst",  aux_rdata, 32'h0);
    check("t5_owner_in_rst",  {30'b0, dbg_rd_owner}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("t5_rvalid_after", {31'b0, aux_rvalid}, 32'h0);
    check("t5_owner_after",  {30'b0, dbg_rd_owner}, 32'h0);
    tick();
    check("t5_rvalid_late", {31'b0, aux_rvalid}, 32'h0);
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_wdata = 32'h1234_5678;
    #1;
    check("t5_core_wr_gnt", {31'b0, core_gnt}, 32'h1);
    check("t5_wr_en",       {31'b0, mem_write_enable}, 32'h1);
    tick();
    core_we = 1'b0;
    check("t5_wr_no_rvalid", {31'b0, core_rvalid}, 32'h0);
    tick();
    core_req = 1'b0;
    check("t5_rd_rvalid", {31'b0, core_rvalid}, 32'h1);
    check("t5_rd_data",   core_rdata, 32'h1234_5678);

    // 6. misaligned address and a cancelled aux request
    core_req = 1'b1; core_addr = 32'h13;
    #1;
    check("t6_misaligned_addr", {2'b0, mem_read_address}, 32'h4);
    check("t6_core_gnt",        {31'b0, core_gnt}, 32'h1);
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    aux_req = 1'b1; aux_addr = 32'h24;
    #1;
    check("t6_aux_denied", {31'b0, aux_gnt}, 32'h0);
`endif
    tick();
    core_req = 1'b0; aux_req = 1'b0;
    #1;
    check("t6_idle_rd_en",   {31'b0, mem_read_enable}, 32'h0);
    check("t6_idle_wr_en",   {31'b0, mem_write_enable}, 32'h0);
    check("t6_idle_addr",    {2'b0, mem_read_address}, 32'h4);
    check("t6_core_rvalid",  {31'b0, core_rvalid}, 32'h1);
    check("t6_core_rdata",   core_rdata, 32'hC0DE_0004);
    tick();
    check("t6_no_aux_rvalid", {31'b0, aux_rvalid}, 32'h0);
    check("t6_no_core_rvalid", {31'b0, core_rvalid}, 32'h0);
    check("t6_wait_idle",     {28'b0, dbg_wait_cnt}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
